// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one combinational ALU between two requesters; ALU_SCHED_FIXED_PRIO_EN selects fixed priority
module alu_op_scheduler #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_cmd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_cmd,
  output logic       req1_ready,
  output logic [3:0] alu_a,
  output logic [1:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  output logic [3:0] rsp_flags,
  output logic [3:0] disp_y,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [1:0] b_q, b_d, sel_q, sel_d;
  logic id_q, id_d, last_q, last_d;
  logic [3:0] ry_q, ry_d, rf_q, rf_d, disp_q, disp_d;
  logic grant, rdy0, rdy1;
  logic [7:0] cmd;
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_op_scheduler: SETTLE_CYCLES must be in 1..15");
  end
  // grant selection: a lone requester wins; ties go by policy
  always_comb begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
    grant = (req0_valid & req1_valid) ? 1'b0 : req1_valid;
`else
    grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;
`endif
    cmd = grant ? req1_cmd : req0_cmd;
  end
  // next-state, handshake and capture logic
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    id_d = id_q;
    last_d = last_q;
    ry_d = ry_q;
    rf_d = rf_q;
    disp_d = disp_q;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = req0_valid & ~grant;
        rdy1 = req1_valid & grant;
        if (rdy0 | rdy1) begin
          a_d = cmd[7:4];
          sel_d = cmd[3:2];
          b_d = cmd[1:0];
          id_d = grant;
          cnt_d = 4'(SETTLE_CYCLES);
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ry_d = alu_y;
          rf_d = alu_flags;
          disp_d = alu_y;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      id_q <= 1'b0;
      last_q <= 1'b1;
      ry_q <= '0;
      rf_q <= '0;
      disp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      id_q <= id_d;
      last_q <= last_d;
      ry_q <= ry_d;
      rf_q <= rf_d;
      disp_q <= disp_d;
    end
  end
  assign req0_ready = rdy0 & ~rst;
  assign req1_ready = rdy1 & ~rst;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_sel = sel_q;
  assign rsp_valid = state_q == DONE;
  assign rsp_id = id_q;
  assign rsp_y = ry_q;
  assign rsp_flags = rf_q;
  assign disp_y = disp_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: randomized scoreboard bench for alu_op_scheduler
module tb_alu_op_scheduler;
  localparam int S = 2;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [7:0] req0_cmd = 0, req1_cmd = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [3:0] alu_a, alu_y, alu_flags, rsp_y, rsp_flags, disp_y;
  logic [1:0] alu_b, alu_sel;
  logic ovr_en = 0;
  logic [3:0] ovr_y = 0, ovr_f = 0;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic id;
    logic [3:0] y;
    logic [3:0] f;
    int due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int ids[$];
  int free_cyc = 0, acc_cyc = -1;
  logic lg = 1, w, acc, exp_v;
  logic [7:0] mcmd = 0, c;

  alu_op_scheduler #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .disp_y(disp_y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference ALU: returns {V,C,N,Z, Y}
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [1:0] s, input logic [1:0] b);
    logic [4:0] r;
    logic v;
    case (s)
      2'd0: begin r = {1'b0, a} + {3'b0, b}; v = ~a[3] & r[3]; end
      2'd1: begin r = {1'b0, a} - {3'b0, b}; v = a[3] & ~r[3]; end
      2'd2: begin r = {1'b0, a & {2'b0, b}}; v = 0; end
      default: begin r = {1'b0, a ^ {2'b0, b}}; v = 0; end
    endcase
    return {v, r[4], r[3], r[3:0] == 4'd0, r[3:0]};
  endfunction

  always_comb begin
    alu_y = ovr_en ? ovr_y : alu_f(alu_a, alu_sel, alu_b)[3:0];
    alu_flags = ovr_en ? ovr_f : alu_f(alu_a, alu_sel, alu_b)[7:4];
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // model + monitor: predicts grants, timing and responses from cycle counts
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      free_cyc = 0;
      acc_cyc = -1;
      lg = 1;
      mcmd = 0;
    end else begin
      exp_v = exp_q.size() > 0 && exp_q[0].due == cyc;
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        if (rsp_valid) begin
          check("rsp_id", rsp_id, e.id);
          check("rsp_y", rsp_y, e.y);
          check("rsp_flags", rsp_flags, e.f);
          check("disp_y", disp_y, e.y);
          ids.push_back(int'(rsp_id));
        end
      end
      check("busy", busy, cyc > acc_cyc && cyc < free_cyc);
      check("alu_ops", {alu_a, alu_sel, alu_b}, mcmd);
      acc = cyc >= free_cyc && (req0_valid || req1_valid);
`ifdef ALU_SCHED_FIXED_PRIO_EN
      w = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
      w = (req0_valid && req1_valid) ? !lg : req1_valid;
`endif
      check("ready", {req0_ready, req1_ready}, {acc && !w, acc && w});
      if (acc) begin
        c = w ? req1_cmd : req0_cmd;
        e.id = w;
        e.y = ovr_en ? ovr_y : alu_f(c[7:4], c[3:2], c[1:0])[3:0];
        e.f = ovr_en ? ovr_f : alu_f(c[7:4], c[3:2], c[1:0])[7:4];
        e.due = cyc + S + 1;
        exp_q.push_back(e);
        acc_cyc = cyc;
        free_cyc = cyc + S + 2;
        lg = w;
        mcmd = c;
      end
    end
  end

  task automatic drive(input bit id, input logic [7:0] cv);
    int n = 0;
    if (id) begin req1_valid = 1; req1_cmd = cv; end
    else begin req0_valid = 1; req0_cmd = cv; end
    do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 200);
    if (n >= 200) fail("drive");
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || cyc < free_cyc) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_ready"}, {req0_ready, req1_ready}, 0);
    check({nm, "_alu"}, {alu_a, alu_sel, alu_b}, 0);
    check({nm, "_rsp"}, {rsp_valid, rsp_id, rsp_y, rsp_flags}, 0);
    check({nm, "_disp"}, disp_y, 0);
  endtask

  task automatic reset_pulse();
    rst = 1;
    #1 check_zero("reset");
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int r;
    #1 rst = 1;
    #1 check_zero("por");
    repeat (3) @(posedge clk);
    #1 rst = 0;
    drive(0, 8'h54);
    wait_idle();
    check("single_alu", {alu_a, alu_sel, alu_b}, {4'd5, 2'd1, 2'd0});
    check("single_rsp", {rsp_id, rsp_y, disp_y}, {1'b0, 4'd5, 4'd5});
    reset_pulse();
    ids.delete();
    fork drive(0, 8'h9B); drive(1, 8'h37); join
    wait_idle();
    check("tie_n", ids.size(), 2);
    if (ids.size() == 2) check("tie_seq", {ids[0][0], ids[1][0]}, 2'b01);
    ids.delete();
`ifdef ALU_SCHED_FIXED_PRIO_EN
    fork
      repeat (6) drive(0, 8'($urandom));
      drive(1, 8'($urandom));
    join
    wait_idle();
    check("fair_n", ids.size(), 7);
    for (int i = 0; i < 6 && i < ids.size(); i++) check("fixed_id", ids[i], 0);
`else
    fork
      repeat (6) drive(0, 8'($urandom));
      repeat (6) drive(1, 8'($urandom));
    join
    wait_idle();
    check("fair_n", ids.size(), 12);
    for (int i = 0; i < 6 && i < ids.size(); i++) check("rr_id", ids[i], i % 2);
`endif
    ids.delete();
    fork
      drive(0, 8'hA5);
      begin repeat (2) @(posedge clk); #1 drive(1, 8'h7E); end
    join
    wait_idle();
    check("block_n", ids.size(), 2);
    check("block_y", rsp_y, alu_f(4'h7, 2'd3, 2'd2)[3:0]);
    drive(0, 8'hF3);
    rst = 1;
    #1 check_zero("midexec");
    @(posedge clk); #1 rst = 0;
    repeat (6) @(negedge clk);
    check("abort_disp", disp_y, 0);
    drive(1, 8'h62);
    wait_idle();
    check("after_abort", disp_y, alu_f(4'h6, 2'd0, 2'd2)[3:0]);
    ovr_en = 1; ovr_y = 4'h0; ovr_f = 4'b1101;
    drive(1, 8'hC6);
    wait_idle();
    ovr_y = 4'hA; ovr_f = 4'b0010;
    repeat (3) @(negedge clk);
    check("flag_hold", {rsp_y, rsp_flags, disp_y}, {4'h0, 4'b1101, 4'h0});
    ovr_en = 0;
    @(posedge clk); #1;
    repeat (30) begin
      r = $urandom_range(0, 2);
      fork
        begin if (r != 1) drive(0, 8'($urandom)); end
        begin if (r != 0) drive(1, 8'($urandom)); end
      join
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
